// File: rtl/conv1_bias_add.sv
// Conv1 bias stage: loads NUM_CH biases from the bias stream, then adds, saturates and forwards
// channel-interleaved accumulator samples. Define CONV1_BIAS_RELU_EN to fuse a ReLU after saturation.
module conv1_bias_add #(
   parameter int NUM_CH = 6,
   parameter int BIAS_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c1_b_en,
   input  logic [BIAS_W-1:0] c1_b,
   input  logic              bias_clr,
   output logic              bias_rdy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        out_ch
);

   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [4:0] LAST_B  = 5'(NUM_CH - 1);
   localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

   typedef enum logic {LOAD, RUN} state_t;

   state_t            state;
   logic [4:0]        bias_cnt;
   logic [3:0]        ch_cnt;
   logic [BIAS_W-1:0] bank [NUM_CH];
   logic [BIAS_W-1:0] bank_sel;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] res;
   logic              accept;

   assign bias_rdy = (state == RUN);
   assign in_ready = (state == RUN) & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;
   assign bank_sel = bank[ch_cnt[IW-1:0]];

   // One guard bit is enough: overflow shows as the two top sum bits disagreeing.
   always_comb begin
      sum = {in_data[DATA_W-1], in_data}
          + {{(DATA_W + 1 - BIAS_W){bank_sel[BIAS_W-1]}}, bank_sel};
      if (sum[DATA_W] != sum[DATA_W-1])
         res = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
         res = sum[DATA_W-1:0];
`ifdef CONV1_BIAS_RELU_EN
      if (res[DATA_W-1])
         res = '0;
`else
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         bias_cnt  <= '0;
         ch_cnt    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++)
            bank[IW'(i)] <= '0;
      end else if (bias_clr) begin
         // Bank contents survive a clear; they are simply overwritten by the next load.
         state     <= LOAD;
         bias_cnt  <= '0;
         ch_cnt    <= '0;
         out_valid <= 1'b0;
      end else begin
         if (state == LOAD && c1_b_en) begin
            bank[bias_cnt[IW-1:0]] <= c1_b;
            bias_cnt               <= bias_cnt + 5'd1;
            if (bias_cnt == LAST_B)
               state <= RUN;
         end
         if (accept) begin
            out_data  <= res;
            out_ch    <= ch_cnt;
            out_valid <= 1'b1;
            ch_cnt    <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + 4'd1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv1_bias_add.sv
// Randomized and directed bench for conv1_bias_add against a cycle-level behavioural model.
module tb_conv1_bias_add;

   localparam int NUM_CH = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c1_b_en = 1'b0;
   logic [7:0]  c1_b = '0;
   logic        bias_clr = 1'b0;
   logic        bias_rdy;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [3:0]  out_ch;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int m_bank [NUM_CH];
   int m_nb;
   int m_ch;
   int m_pv;
   int m_pdata;
   int m_pch;

   conv1_bias_add #(.NUM_CH(NUM_CH), .BIAS_W(8), .DATA_W(16)) dut (
      .clk(clk), .rst(rst), .c1_b_en(c1_b_en), .c1_b(c1_b), .bias_clr(bias_clr),
      .bias_rdy(bias_rdy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int biased(input int x, input int b);
      int s;
      s = x + b;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`ifdef CONV1_BIAS_RELU_EN
      if (s < 0) s = 0;
`endif
      return s;
   endfunction

   // One clock: apply inputs, predict handshake, advance the model, compare after the edge.
   task automatic step(input logic r, input logic be, input logic [7:0] b, input logic clr,
                       input logic iv, input logic [15:0] d, input logic ordy);
      int exp_irdy;
      int acc;
      rst = r; c1_b_en = be; c1_b = b; bias_clr = clr;
      in_valid = iv; in_data = d; out_ready = ordy;
      #1;
      exp_irdy = (m_nb == NUM_CH && (m_pv == 0 || ordy)) ? 1 : 0;
      check("in_ready", int'(in_ready), exp_irdy);
      acc = (iv && exp_irdy) ? 1 : 0;
      if (r) begin
         foreach (m_bank[i]) m_bank[i] = 0;
         m_nb = 0; m_ch = 0; m_pv = 0; m_pdata = 0; m_pch = 0;
      end else if (clr) begin
         m_nb = 0; m_ch = 0; m_pv = 0;
      end else begin
         if (acc) begin
            m_pv    = 1;
            m_pdata = biased(int'($signed(d)), m_bank[m_ch]);
            m_pch   = m_ch;
            m_ch    = (m_ch + 1) % NUM_CH;
         end else if (ordy) begin
            m_pv = 0;
         end
         if (be && m_nb < NUM_CH) begin
            m_bank[m_nb] = int'($signed(b));
            m_nb++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("bias_rdy", int'(bias_rdy), (m_nb == NUM_CH) ? 1 : 0);
      check("out_valid", int'(out_valid), m_pv);
      check("out_data", int'($signed(out_data)), m_pdata);
      check("out_ch", int'(out_ch), m_pch);
   endtask

   task automatic load_std();
      int bl [NUM_CH] = '{1, -2, 3, -4, 5, -6};
      foreach (bl[i]) step(0, 1, 8'(bl[i]), 0, 1, 16'd7, 1);
   endtask

   initial begin
      logic [15:0] d;
      logic [7:0]  b;
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 8'h11, 0, 1, 16'd5, 1);
      step(0, 0, 0, 0, 0, 0, 0);

      load_std();
      for (int i = 0; i < NUM_CH; i++) step(0, 0, 0, 0, 1, 16'd100, 1);
      step(0, 1, 8'h7F, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 16'd0, 1);

      // Saturation: ch1..3 get zero, ch4 (bias 5) max, ch5 (bias -6) min.
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 16'd0, 1);
      step(0, 0, 0, 0, 1, 16'h7FFF, 1);
      step(0, 0, 0, 0, 1, 16'h8000, 1);

      // Backpressure with continuous offer, then release.
      step(0, 0, 0, 0, 1, 16'd11, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 16'(20 + i), 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 16'(30 + i), 1);

      // Clear mid-stream, reload, ReLU-relevant samples on ch0/ch1.
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 16'(40 + i), 0);
      step(0, 1, 8'h55, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 16'd9, 1);
      load_std();
      step(0, 0, 0, 0, 1, 16'(-50), 1);
      step(0, 0, 0, 0, 1, 16'd50, 1);
      step(0, 0, 0, 0, 0, 0, 1);

      for (int n = 0; n < 3000; n++) begin
         d = 16'($urandom);
         if ($urandom_range(7) == 0) d = ($urandom_range(1) == 0) ? 16'h7FFF : 16'h8000;
         b = 8'($urandom);
         step(($urandom_range(400) == 0), ($urandom_range(2) == 0), b,
              ($urandom_range(60) == 0), ($urandom_range(9) < 7), d,
              ($urandom_range(9) < 6));
      end
      step(0, 0, 0, 0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
